axilite_gpio_in: RTL and testbench
==================================

// Module: axilite_gpio_in
// PURPOSE
// - AXI4-Lite slave, input-direction GPIO peripheral; counterpart of the existing GPIO-out slave on the SoC crossbar.
// - Samples NUM_GPIO asynchronous pins through a synchroniser and exposes the pin levels as a register.
// - Latches selected edges into a sticky status register and raises a level interrupt on the SoC IRQ vector.
// PARAMETERS
// - NUM_GPIO     8   number of input pins, 1..32
// - SYNC_STAGES  2   synchroniser flops per pin, >=2
// - ADDR_WIDTH   32  AXI address width; only addr[11:0] is decoded
// PORTS
// - clock_i            in   1           system clock
// - reset_i            in   1           synchronous, active-high reset
// - s_axilite_awaddr   in   ADDR_WIDTH  write address
// - s_axilite_awvalid  in   1   / s_axilite_awready out 1
// - s_axilite_wdata    in   32  / s_axilite_wstrb   in  4
// - s_axilite_wvalid   in   1   / s_axilite_wready  out 1
// - s_axilite_bresp    out  2   / s_axilite_bvalid  out 1 / s_axilite_bready in 1
// - s_axilite_araddr   in   ADDR_WIDTH  read address
// - s_axilite_arvalid  in   1   / s_axilite_arready out 1
// - s_axilite_rdata    out  32  / s_axilite_rresp   out 2
// - s_axilite_rvalid   out  1   / s_axilite_rready  in  1
// - gpio_i             in   NUM_GPIO    asynchronous pins
// - int_o              out  1           level interrupt, registered
// BEHAVIOUR
// - Registers (word offsets, addr[1:0] ignored). Bits >= NUM_GPIO read 0; writes to them are ignored.
//   - 0x00 DATA: RO, synchronised levels.
//   - 0x04 IRQ_EN: RW.
//   - 0x08 EDGE_SEL: RW, per bit 0=rising, 1=falling.
//   - 0x0C STATUS: RW1C.
// - Offsets 0x010-0xFFF: SLVERR (2'b10), rdata=0, no state change. All other accesses respond OKAY (2'b00).
// - Reset: every ready/valid, resp, rdata and int_o is 0; all registers, sync flops, prev-sample and warm-up counter are 0.
// - Write FSM (W_IDLE, W_RESP):
//   - In W_IDLE, awready=wready=1 only in a cycle where awvalid&&wvalid.
//   - That cycle: wstrb-masked register update, then go to W_RESP.
//   - W_RESP: bvalid=1 held until bready, then back to W_IDLE.
//   - A lone AW or lone W is never accepted.
// - Read FSM (R_IDLE, R_RESP):
//   - R_IDLE: arready=1. On arvalid, latch rdata/rresp and go to R_RESP.
//   - R_RESP: rvalid=1 held stable until rready, then R_IDLE.
// - Read and write channels are independent and may complete in the same cycle.
// - Latency:
//   - Pin change -> DATA: SYNC_STAGES cycles.
//   - STATUS set: +1 cycle after DATA.
//   - int_o: +1 cycle after STATUS.
//   - Write to response: bvalid 1 cycle after the AW/W handshake.
//   - Read to data: rvalid 1 cycle after the AR handshake.
// - Edge detection:
//   - edge = EDGE_SEL ? (prev & ~sync) : (~prev & sync).
//   - STATUS |= edge. STATUS bits are set irrespective of IRQ_EN.
//   - int_o <= |(STATUS & IRQ_EN).
// - Warm-up: edge detection is suppressed until SYNC_STAGES+1 cycles after reset deassertion (saturating counter), so pins high at reset release do not create a spurious edge.
// - Simultaneous W1C and new edge on the same bit: set wins (bit stays 1).
// - Changing EDGE_SEL takes effect on the next sample; it never sets STATUS by itself.
// - Reset mid-transaction: the handshake is abandoned; bvalid/rvalid drop next cycle with no response issued.
// STRUCTURE
// - uninasoc_pkg:
//   - NUM_GPIO_IN becomes this block's NUM_GPIO.
//   - NUM_IRQ and NUM_AXI_SLAVES are recounted.
//   - Add GPIO_IN_*_OFFSET constants and axi_resp_t enum {OKAY=0, SLVERR=2}.
// - One sub-module: gpio_sync (SYNC_STAGES-deep flop chain, synchronous reset, parameterised width).
// TESTING
// - Reset release with gpio_i=8'hFF -> DATA=0xFF after 2 cycles; STATUS stays 0; int_o stays 0.
// - IRQ_EN=0x01, EDGE_SEL=0; gpio_i[0] 0->1 -> STATUS=0x01 at cycle 3; int_o=1 at cycle 4.
//   - Then write STATUS=0x01 -> STATUS=0; int_o=0 the next cycle.
// - EDGE_SEL=0x80, IRQ_EN=0x80; gpio_i[7] 1->0 -> STATUS[7]=1; the rising edge on pin 7 is ignored.
// - W1C of STATUS[2] in the same cycle as a detected edge on pin 2 -> STATUS[2]=1 after the write.
// - Read 0x010 and write 0x100 -> SLVERR with rdata=0, registers unchanged.
//   - AW without W for 5 cycles -> awready stays 0.
//   - rready held low 4 cycles -> rvalid/rdata stable throughout.
// - Write with wstrb=4'b0001, wdata=0xFFFF_FFFF to IRQ_EN (NUM_GPIO=12) -> IRQ_EN=0x0FF.
//   - Then write wstrb=4'b0010 -> IRQ_EN=0xFFF.
//   - Read of IRQ_EN then returns 0x0000_0FFF.

Source files
------------

// File: rtl/uninasoc_pkg.sv
// -----------------------------------------------------------------------------
// uninasoc_pkg
// SoC-wide constants shared by the crossbar slaves, plus the GPIO-in register
// map, the AXI response encoding and small mask helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package uninasoc_pkg;

    // Peripheral population
    localparam int NUM_GPIO_OUT   = 8;
    localparam int NUM_GPIO_IN    = 8;
    localparam int NUM_UART       = 1;

    // IRQ vector: one line per UART plus the GPIO-in level interrupt
    localparam int NUM_IRQ        = NUM_UART + 1;

    // Crossbar slaves: main memory, UART, GPIO-out, GPIO-in
    localparam int NUM_AXI_SLAVES = 4;

    // GPIO-in register map (byte offsets inside the 4 KiB window)
    localparam logic [11:0] GPIO_IN_DATA_OFFSET     = 12'h000;
    localparam logic [11:0] GPIO_IN_IRQ_EN_OFFSET   = 12'h004;
    localparam logic [11:0] GPIO_IN_EDGE_SEL_OFFSET = 12'h008;
    localparam logic [11:0] GPIO_IN_STATUS_OFFSET   = 12'h00C;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    // Ones in bit positions below n; used to keep unimplemented pins at zero.
    function automatic logic [31:0] gpio_mask(input int n);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < n) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Expand a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Multi-flop synchroniser for asynchronous input pins.
// Ports:
//   clk     - system clock
//   rst     - synchronous, active-high reset (clears every stage)
//   pins    - asynchronous inputs, WIDTH bits
//   levels  - synchronised levels, STAGES cycles behind pins
// -----------------------------------------------------------------------------
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] levels
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the pin levels through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= pins;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign levels = stage_r[STAGES-1];

endmodule

// File: rtl/axilite_gpio_in.sv
// -----------------------------------------------------------------------------
// axilite_gpio_in
// AXI4-Lite input GPIO: synchronised pin levels (DATA), interrupt enable
// (IRQ_EN), per-pin edge polarity (EDGE_SEL) and sticky edge flags (STATUS,
// write-one-to-clear). int_o is a registered level interrupt.
// Ports:
//   clock_i, reset_i   - clock, synchronous active-high reset
//   s_axilite_aw*/w*/b* - write address/data/response channels
//   s_axilite_ar*/r*    - read address/data channels
//   gpio_i             - asynchronous pins, NUM_GPIO bits
//   int_o              - |(STATUS & IRQ_EN), registered
// Only addr[11:2] is decoded; offsets 0x010..0xFFF answer SLVERR.
// -----------------------------------------------------------------------------
module axilite_gpio_in
    import uninasoc_pkg::*;
#(
    parameter int NUM_GPIO    = NUM_GPIO_IN,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
    input  logic                  s_axilite_awvalid,
    output logic                  s_axilite_awready,
    input  logic [31:0]           s_axilite_wdata,
    input  logic [3:0]            s_axilite_wstrb,
    input  logic                  s_axilite_wvalid,
    output logic                  s_axilite_wready,
    output logic [1:0]            s_axilite_bresp,
    output logic                  s_axilite_bvalid,
    input  logic                  s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
    input  logic                  s_axilite_arvalid,
    output logic                  s_axilite_arready,
    output logic [31:0]           s_axilite_rdata,
    output logic [1:0]            s_axilite_rresp,
    output logic                  s_axilite_rvalid,
    input  logic                  s_axilite_rready,
    input  logic [NUM_GPIO-1:0]   gpio_i,
    output logic                  int_o
);

    localparam logic [31:0] PIN_MASK = gpio_mask(NUM_GPIO);
    localparam int          WARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t            w_state_r;
    r_state_t            r_state_r;
    logic                live_r;
    logic                arready_r;
    logic                bvalid_r;
    logic                rvalid_r;
    logic                int_r;
    axi_resp_t           bresp_r;
    axi_resp_t           rresp_r;
    logic [31:0]         rdata_r;
    logic [31:0]         irq_en_r;
    logic [31:0]         edge_sel_r;
    logic [31:0]         status_r;
    logic [NUM_GPIO-1:0] prev_r;
    logic [WARM_W-1:0]   warm_r;

    logic [NUM_GPIO-1:0] sync_s;
    logic [31:0]         data_s;
    logic [31:0]         prev_s;
    logic [31:0]         edge_s;
    logic [31:0]         wr_bits_s;
    logic [31:0]         wr_keep_s;
    logic [31:0]         irq_en_nxt_s;
    logic [31:0]         edge_sel_nxt_s;
    logic [31:0]         status_nxt_s;
    logic [31:0]         rd_val_s;
    logic                warm_done_s;
    logic                wr_fire_s;
    logic                rd_fire_s;
    logic                wr_err_s;
    logic                rd_err_s;
    axi_resp_t           wr_resp_s;
    axi_resp_t           rd_resp_s;
    logic                unused_addr_s;

    gpio_sync #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clock_i),
        .rst    (reset_i),
        .pins   (gpio_i),
        .levels (sync_s)
    );

    assign data_s      = 32'(sync_s);
    assign prev_s      = 32'(prev_r);
    assign warm_done_s = (warm_r == WARM_DONE);

    // live_r keeps awready low while reset is held, since awready is decoded
    // straight from the request valids.
    assign wr_fire_s = live_r && (w_state_r == W_IDLE) && s_axilite_awvalid && s_axilite_wvalid;
    assign rd_fire_s = arready_r && s_axilite_arvalid;
    assign wr_err_s  = (s_axilite_awaddr[11:4] != 8'h00);
    assign rd_err_s  = (s_axilite_araddr[11:4] != 8'h00);

    assign wr_keep_s = strb_mask(s_axilite_wstrb) & PIN_MASK;
    assign wr_bits_s = s_axilite_wdata & wr_keep_s;

    assign unused_addr_s = ^{s_axilite_awaddr[ADDR_WIDTH-1:12], s_axilite_awaddr[1:0],
                             s_axilite_araddr[ADDR_WIDTH-1:12], s_axilite_araddr[1:0]};

    // Per-pin edge qualification; idle until the synchroniser has flushed
    always_comb begin
        edge_s = 32'h0000_0000;
        if (warm_done_s) begin
            edge_s = ((edge_sel_r & prev_s & ~data_s) | (~edge_sel_r & ~prev_s & data_s)) & PIN_MASK;
        end else begin
            edge_s = 32'h0000_0000;
        end
    end

    // Next register values: byte-masked writes, W1C on STATUS with set priority
    always_comb begin
        irq_en_nxt_s   = irq_en_r;
        edge_sel_nxt_s = edge_sel_r;
        status_nxt_s   = status_r | edge_s;
        if (wr_fire_s && !wr_err_s) begin
            case (s_axilite_awaddr[3:2])
                2'd1:    irq_en_nxt_s   = (irq_en_r & ~wr_keep_s) | wr_bits_s;
                2'd2:    edge_sel_nxt_s = (edge_sel_r & ~wr_keep_s) | wr_bits_s;
                2'd3:    status_nxt_s   = (status_r & ~wr_bits_s) | edge_s;
                default: status_nxt_s   = status_r | edge_s;
            endcase
        end else begin
            status_nxt_s = status_r | edge_s;
        end
    end

    // Read data mux and response codes
    always_comb begin
        rd_val_s  = 32'h0000_0000;
        rd_resp_s = OKAY;
        wr_resp_s = OKAY;
        if (rd_err_s) begin
            rd_val_s  = 32'h0000_0000;
            rd_resp_s = SLVERR;
        end else begin
            case (s_axilite_araddr[3:2])
                2'd0:    rd_val_s = data_s;
                2'd1:    rd_val_s = irq_en_r;
                2'd2:    rd_val_s = edge_sel_r;
                2'd3:    rd_val_s = status_r;
                default: rd_val_s = 32'h0000_0000;
            endcase
        end
        if (wr_err_s) begin
            wr_resp_s = SLVERR;
        end else begin
            wr_resp_s = OKAY;
        end
    end

    // Register file, edge history, warm-up counter and interrupt
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            live_r     <= 1'b0;
            irq_en_r   <= 32'h0000_0000;
            edge_sel_r <= 32'h0000_0000;
            status_r   <= 32'h0000_0000;
            prev_r     <= {NUM_GPIO{1'b0}};
            warm_r     <= {WARM_W{1'b0}};
            int_r      <= 1'b0;
        end else begin
            live_r     <= 1'b1;
            irq_en_r   <= irq_en_nxt_s;
            edge_sel_r <= edge_sel_nxt_s;
            status_r   <= status_nxt_s;
            prev_r     <= sync_s;
            if (!warm_done_s) begin
                warm_r <= warm_r + WARM_W'(1);
            end
            int_r      <= |(status_r & irq_en_r);
        end
    end

    // Write channel FSM: joint AW/W acceptance, then hold B until taken
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            bresp_r   <= OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (wr_fire_s) begin
                        bvalid_r  <= 1'b1;
                        bresp_r   <= wr_resp_s;
                        w_state_r <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axilite_bready) begin
                        bvalid_r  <= 1'b0;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    bvalid_r  <= 1'b0;
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: latch data on AR, hold R stable until taken
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= OKAY;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (rd_fire_s) begin
                        rdata_r   <= rd_val_s;
                        rresp_r   <= rd_resp_s;
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_RESP;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axilite_rready) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        r_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_r  <= 1'b0;
                    arready_r <= 1'b0;
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axilite_awready = wr_fire_s;
    assign s_axilite_wready  = wr_fire_s;
    assign s_axilite_bvalid  = bvalid_r;
    assign s_axilite_bresp   = bresp_r;
    assign s_axilite_arready = arready_r;
    assign s_axilite_rvalid  = rvalid_r;
    assign s_axilite_rdata   = rdata_r;
    assign s_axilite_rresp   = rresp_r;
    assign int_o             = int_r;

endmodule

// File: tb/tb_axilite_gpio_in.sv
// -----------------------------------------------------------------------------
// tb_axilite_gpio_in
// Directed bench for axilite_gpio_in (NUM_GPIO=12). Stimulus pushes the
// expected B/R responses into queues; a monitor pops and compares them on
// every accepted response beat.
// -----------------------------------------------------------------------------
module tb_axilite_gpio_in;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [11:0] gpio;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  b_exp_q [$];
    logic [33:0] r_exp_q [$];

    axilite_gpio_in #(
        .NUM_GPIO    (12),
        .SYNC_STAGES (2),
        .ADDR_WIDTH  (32)
    ) dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .s_axilite_awaddr  (awaddr),
        .s_axilite_awvalid (awvalid),
        .s_axilite_awready (awready),
        .s_axilite_wdata   (wdata),
        .s_axilite_wstrb   (wstrb),
        .s_axilite_wvalid  (wvalid),
        .s_axilite_wready  (wready),
        .s_axilite_bresp   (bresp),
        .s_axilite_bvalid  (bvalid),
        .s_axilite_bready  (bready),
        .s_axilite_araddr  (araddr),
        .s_axilite_arvalid (arvalid),
        .s_axilite_arready (arready),
        .s_axilite_rdata   (rdata),
        .s_axilite_rresp   (rresp),
        .s_axilite_rvalid  (rvalid),
        .s_axilite_rready  (rready),
        .gpio_i            (gpio),
        .int_o             (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: compare every accepted B/R beat with the queue head
    always @(negedge clk) begin
        logic [1:0]  be;
        logic [33:0] re;
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (b_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL bresp_unexpected: got 0x%0h with nothing expected", bresp);
            end else begin
                be = b_exp_q.pop_front();
                chk("bresp", 32'(bresp), 32'(be));
            end
        end
        if (rvalid === 1'b1 && rready === 1'b1) begin
            if (r_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rresp_unexpected: got data 0x%08h with nothing expected", rdata);
            end else begin
                re = r_exp_q.pop_front();
                chk("rdata", rdata, re[31:0]);
                chk("rresp", 32'(rresp), 32'(re[33:32]));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        bit done;
        done = 1'b0;
        b_exp_q.push_back(resp);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (awready === 1'b1 && wready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL aw_handshake: no accept at addr 0x%08h, required within 20 cycles", addr);
            void'(b_exp_q.pop_back());
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        bit done;
        done = 1'b0;
        r_exp_q.push_back({resp, data});
        araddr = addr; arvalid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (arready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ar_handshake: no accept at addr 0x%08h, required within 20 cycles", addr);
            void'(r_exp_q.pop_back());
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (b_exp_q.size() != 0 || r_exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d B and %0d R responses outstanding, required 0",
                     b_exp_q.size(), r_exp_q.size());
            b_exp_q.delete();
            r_exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1; gpio = 12'h0FF;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'h0);
        chk("rst_bvalid",  32'(bvalid),  32'h0);
        chk("rst_rvalid",  32'(rvalid),  32'h0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_int",     32'(irq),     32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pins high at release: DATA follows, no spurious edge
        wait_cycles(6);
        axi_read(32'h000, 32'h0000_00FF, 2'b00);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();
        chk("warm_int", 32'(irq), 32'h0);

        // Rising edge on pin 0 with interrupt latency
        axi_write(32'h004, 32'h0000_0001, 4'hF, 2'b00);
        axi_write(32'h008, 32'h0000_0000, 4'hF, 2'b00);
        gpio[0] = 1'b0;
        wait_cycles(6);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();
        gpio[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("int_latency", 32'(irq), 32'(k == 4));
        end
        axi_read(32'h00C, 32'h0000_0001, 2'b00);
        axi_write(32'h00C, 32'h0000_0001, 4'hF, 2'b00);
        chk("int_before_clear", 32'(irq), 32'h1);
        @(posedge clk); #1;
        chk("int_after_clear", 32'(irq), 32'h0);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();

        // Falling edge on pin 7, rising ignored
        axi_write(32'h008, 32'h0000_0080, 4'hF, 2'b00);
        axi_write(32'h004, 32'h0000_0080, 4'hF, 2'b00);
        wait_cycles(6);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();
        gpio[7] = 1'b0;
        wait_cycles(6);
        axi_read(32'h00C, 32'h0000_0080, 2'b00);
        drain();
        chk("fall_int", 32'(irq), 32'h1);
        axi_write(32'h00C, 32'h0000_0080, 4'hF, 2'b00);
        wait_cycles(3);
        chk("fall_int_clr", 32'(irq), 32'h0);
        gpio[7] = 1'b1;
        wait_cycles(6);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();
        chk("rise7_int", 32'(irq), 32'h0);

        // W1C of STATUS[2] in the same cycle as its edge: set wins
        gpio[2] = 1'b0;
        wait_cycles(6);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();
        gpio[2] = 1'b1;
        b_exp_q.push_back(2'b00);
        wait_cycles(2);
        awaddr = 32'h00C; wdata = 32'h0000_0004; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("w1c_race_awready", 32'(awready), 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        axi_read(32'h00C, 32'h0000_0004, 2'b00);
        axi_write(32'h00C, 32'h0000_0004, 4'hF, 2'b00);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        drain();

        // Out-of-range offsets
        axi_read(32'h010, 32'h0000_0000, 2'b10);
        axi_read(32'hFFC, 32'h0000_0000, 2'b10);
        axi_write(32'h100, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_write(32'h104, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_read(32'h004, 32'h0000_0080, 2'b00);
        axi_read(32'h008, 32'h0000_0080, 2'b00);
        drain();

        // Lone AW, then lone W: neither accepted
        awaddr = 32'h004; awvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lone_aw_awready", 32'(awready), 32'h0);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lone_w_wready", 32'(wready), 32'h0);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;

        // Byte strobes with 12 implemented bits
        axi_write(32'h004, 32'hFFFF_FFFF, 4'b0001, 2'b00);
        axi_read(32'h004, 32'h0000_00FF, 2'b00);
        axi_write(32'h004, 32'hFFFF_FFFF, 4'b0010, 2'b00);
        axi_read(32'h004, 32'h0000_0FFF, 2'b00);
        axi_write(32'h004, 32'hFFFF_FFFF, 4'b1100, 2'b00);
        axi_read(32'h004, 32'h0000_0FFF, 2'b00);
        drain();

        // rready held low: R beat stays stable
        rready = 1'b0;
        axi_read(32'h004, 32'h0000_0FFF, 2'b00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_rvalid", 32'(rvalid), 32'h1);
            chk("hold_rdata",  rdata,       32'h0000_0FFF);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        drain();

        // Mixed pin pattern, DATA write ignored
        gpio = 12'hA5C;
        wait_cycles(6);
        axi_read(32'h000, 32'h0000_0A5C, 2'b00);
        axi_read(32'h00C, 32'h0000_0A80, 2'b00);
        axi_write(32'h000, 32'h0000_0000, 4'hF, 2'b00);
        axi_read(32'h000, 32'h0000_0A5C, 2'b00);
        drain();
        chk("mixed_int", 32'(irq), 32'h1);

        // Reset while a read response is pending
        rready = 1'b0;
        axi_read(32'h00C, 32'h0000_0A80, 2'b00);
        @(negedge clk);
        chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rvalid",  32'(rvalid),  32'h0);
        chk("mid_rst_arready", 32'(arready), 32'h0);
        chk("mid_rst_int",     32'(irq),     32'h0);
        r_exp_q.delete();
        rready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cycles(6);
        axi_read(32'h004, 32'h0000_0000, 2'b00);
        axi_read(32'h008, 32'h0000_0000, 2'b00);
        axi_read(32'h00C, 32'h0000_0000, 2'b00);
        axi_read(32'h000, 32'h0000_0A5C, 2'b00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
